ota_offset_trim_ctrl: RTL and testbench
=======================================

Name: ota_offset_trim_ctrl

Overview:
- Digital controller that calibrates the on-chip OTA input offset.
- Runs an auto-zero phase, then a successive-approximation (SAR) search of a binary trim DAC code, steered by a comparator observing the OTA output.
- Sits in the digital section beside the analog macro: drives the auto-zero switch enable and the trim DAC code bits, and reads the comparator decision.
- Also supports a manual trim-code override for characterisation.

Parameters:
- TRIM_W, 6, trim DAC code width (bits); legal range 2..8.
- CNT_W, 8, width of the settle counter and the settle_cycles input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- ena  input  1  block enable; when low, FSM and counter freeze (synchronizer still runs).
- start  input  1  calibration request; level-sampled.
- abort  input  1  cancel calibration.
- comp_in  input  1  asynchronous comparator decision; 1 = present code too high.
- settle_cycles  input  CNT_W  settle length S; each AZ/SETTLE phase lasts S+1 cycles.
- manual_en  input  1  select manual_code on trim_code when not busy.
- manual_code  input  TRIM_W  manual trim value.
- trim_code  output  TRIM_W  trim DAC drive.
- az_en  output  1  auto-zero switch enable.
- busy  output  1  high in AZ, SETTLE or SAMPLE.
- done  output  1  one-cycle pulse on entry to DONE.
- trim_valid  output  1  high while in DONE (calibrated code valid).

Behaviour:
- Synchronizer: comp_in passes through 2 flops to give comp_s, which the FSM uses. Reset value of both flops is 0.
- Reset values:
  - state = IDLE.
  - code register = midscale, 1<<(TRIM_W-1).
  - bit_idx = TRIM_W-1.
  - counter = 0.
  - az_en, busy, done, trim_valid = 0.
- trim_code output mux: manual_code when manual_en=1 and state is IDLE or DONE; otherwise the code register. manual_en is ignored while busy.
- Counter rule: on entry to AZ or SETTLE, load counter with settle_cycles, then decrement each cycle. Exit the phase in the cycle where counter==0. The phase therefore lasts S+1 cycles; S=0 gives 1 cycle.
- IDLE:
  - start=1 and manual_en=0 → go to AZ next cycle.
  - Otherwise stay in IDLE.
- AZ:
  - az_en=1.
  - On exit: az_en=0, code register = 1<<(TRIM_W-1), bit_idx = TRIM_W-1, go to SETTLE.
- SETTLE: wait per the counter rule, then go to SAMPLE.
- SAMPLE (1 cycle):
  - If comp_s=1, clear code[bit_idx]; else keep it.
  - If bit_idx==0 → go to DONE.
  - Else decrement bit_idx, set code[bit_idx-1], and go to SETTLE.
- DONE:
  - done=1 for the entry cycle only; trim_valid=1 for the whole stay.
  - start=1 with manual_en=0 → go to AZ (recalibrate); trim_valid drops in that cycle.
- Latency: from the cycle start is accepted to DONE entry is (S+1) + TRIM_W·(S+2) cycles.
- Settling requirement: S ≥ 2 is required for a correct comparator decision, since the synchronizer adds 2 cycles. Smaller S is legal but gives undefined results.
- abort:
  - Takes priority over start.
  - From any state: go to IDLE next cycle; code register = midscale; az_en=0; trim_valid=0; no done pulse.
- ena=0: state, counter, bit_idx and code hold; outputs hold. abort still acts, with priority over ena.
- settle_cycles is sampled only at counter load; mid-phase changes do not affect the current phase.
- start held high continuously in DONE: the block restarts each time DONE is entered (back-to-back calibrations).
- Reset mid-operation: all outputs return to reset values immediately (asynchronous).

Test Plan:
1. S=3, comparator model comp_in = (trim_code > 37), pulse start:
   - trim_code trial sequence 32,48,40,36,38,37.
   - Final code 37 (100101).
   - done pulse exactly 4+6·5=34 cycles after the start-accept cycle; trim_valid high afterward.
   - az_en high for cycles 1..4 only.
2. comp_in tied 1 → final code 000000. comp_in tied 0 → final code 111111. Both with S=2, latency 3+6·4=27 cycles.
3. abort asserted during the SETTLE of bit 3 → IDLE next cycle; trim_code=32; busy=0; no done pulse; a later start completes normally to code 37.
4. manual_en=1, manual_code=0x15:
   - In IDLE, trim_code=0x15 and start is ignored.
   - After a calibration to 37, toggling manual_en switches trim_code between 0x15 and 37.
   - manual_en=1 during busy has no effect.
5. ena dropped for 10 cycles mid-SETTLE → state, counter and trim_code frozen; total latency extended by exactly 10 cycles; final code still 37.
6. rst_n asserted mid-SAMPLE → immediate return to trim_code=32 with az_en, busy, done, trim_valid = 0. After release, start with S=0 completes in 1+6·2=13 cycles.

Source files
------------

// File: rtl/ota_offset_trim_ctrl.sv
// ota_offset_trim_ctrl
//   Calibrates the OTA input offset. The block first closes the auto-zero
//   switch, then runs a successive-approximation search over the binary trim
//   DAC code. The search is steered by the comparator that watches the OTA
//   output. A manual code can be driven onto the DAC for characterisation.
//
// Ports
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   ena_i            block enable; low freezes FSM/counter (synchronizer runs)
//   start_i          calibration request (level-sampled in IDLE/DONE)
//   abort_i          cancel; returns to IDLE, overrides start and ena
//   comp_in_i        asynchronous comparator decision, 1 = code too high
//   settle_cycles_i  settle length S; each AZ/SETTLE phase lasts S+1 cycles
//   manual_en_i      drive manual_code_i on trim_code_o while not busy
//   manual_code_i    manual trim value
//   trim_code_o      trim DAC drive
//   az_en_o          auto-zero switch enable
//   busy_o           high in AZ, SETTLE or SAMPLE
//   done_o           one-cycle pulse on entry to DONE
//   trim_valid_o     high while the calibrated code is valid (DONE)
module ota_offset_trim_ctrl #(
  parameter int TRIM_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ena_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              comp_in_i,
  input  logic [CNT_W-1:0]  settle_cycles_i,
  input  logic              manual_en_i,
  input  logic [TRIM_W-1:0] manual_code_i,
  output logic [TRIM_W-1:0] trim_code_o,
  output logic              az_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              trim_valid_o
);

  localparam int IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [TRIM_W-1:0] MIDSCALE = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  TOP_IDX  = IDX_W'(TRIM_W - 1);
  localparam logic [TRIM_W-1:0] ONE_HOT0 = {{(TRIM_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AZ     = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e            state_q;
  logic [TRIM_W-1:0] code_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              az_en_q;
  logic              busy_q;
  logic              done_q;
  logic              trim_valid_q;

  // Two-flop synchronizer for the comparator; runs regardless of ena_i.
  logic comp_meta_q;
  logic comp_s_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      comp_meta_q <= 1'b0;
      comp_s_q    <= 1'b0;
    end else begin
      comp_meta_q <= comp_in_i;
      comp_s_q    <= comp_meta_q;
    end
  end

  // SAR step: drop the bit under test if the comparator says the code is
  // too high, then (if more bits remain) raise the next lower bit as trial.
  logic [TRIM_W-1:0] bit_mask_d;
  logic [TRIM_W-1:0] sampled_code_d;
  logic [TRIM_W-1:0] next_trial_d;

  always_comb begin
    bit_mask_d     = ONE_HOT0 << bit_idx_q;
    sampled_code_d = comp_s_q ? (code_q & ~bit_mask_d) : code_q;
    next_trial_d   = sampled_code_d | (bit_mask_d >> 1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      code_q       <= MIDSCALE;
      bit_idx_q    <= TOP_IDX;
      cnt_q        <= '0;
      az_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trim_valid_q <= 1'b0;
    end else if (abort_i) begin
      state_q      <= IDLE;
      code_q       <= MIDSCALE;
      bit_idx_q    <= TOP_IDX;
      cnt_q        <= '0;
      az_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trim_valid_q <= 1'b0;
    end else if (ena_i) begin
      // done is a pulse; cleared here so a frozen block holds its outputs.
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i && !manual_en_i) begin
            state_q      <= AZ;
            cnt_q        <= settle_cycles_i;
            az_en_q      <= 1'b1;
            busy_q       <= 1'b1;
            trim_valid_q <= 1'b0;
          end
        end
        AZ: begin
          if (cnt_q == '0) begin
            state_q   <= SETTLE;
            cnt_q     <= settle_cycles_i;
            az_en_q   <= 1'b0;
            code_q    <= MIDSCALE;
            bit_idx_q <= TOP_IDX;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        SAMPLE: begin
          if (bit_idx_q == '0) begin
            state_q      <= DONE;
            code_q       <= sampled_code_d;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            trim_valid_q <= 1'b1;
          end else begin
            state_q   <= SETTLE;
            code_q    <= next_trial_d;
            bit_idx_q <= bit_idx_q - IDX_W'(1);
            cnt_q     <= settle_cycles_i;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          az_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Manual override only applies while no calibration is in flight.
  assign trim_code_o  = (manual_en_i && (state_q == IDLE || state_q == DONE))
                        ? manual_code_i : code_q;
  assign az_en_o      = az_en_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign trim_valid_o = trim_valid_q;

endmodule

// File: tb/tb_ota_offset_trim_ctrl.sv
module tb_ota_offset_trim_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena, start, abort, comp_in, manual_en;
  logic [7:0] settle_cycles;
  logic [5:0] manual_code;
  logic [5:0] trim_code;
  logic       az_en, busy, done, trim_valid;

  int vectors = 0;
  int miscompares = 0;

  // Analog stand-in: comparator trips when the trim code exceeds the target.
  int target = 37;
  always_comb comp_in = (int'(trim_code) > target);

  always #5 clk = ~clk;

  ota_offset_trim_ctrl #(.TRIM_W(6), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .start_i(start), .abort_i(abort),
    .comp_in_i(comp_in), .settle_cycles_i(settle_cycles), .manual_en_i(manual_en),
    .manual_code_i(manual_code), .trim_code_o(trim_code), .az_en_o(az_en),
    .busy_o(busy), .done_o(done), .trim_valid_o(trim_valid)
  );

  // Results of the last run_cal
  int trials_q[$];
  int exp_q[$];
  int lat_g, az_cnt_g, az_first_g, frozen_bad_g, exp_final;
  bit keep_start = 0;
  bit man_busy = 0;

  // Reference: greedy binary search for the largest code not above target.
  task automatic model_sar(input int t);
    int code;
    code = 0;
    exp_q.delete();
    for (int b = 5; b >= 0; b--) begin
      exp_q.push_back(code + (1 << b));
      if (code + (1 << b) <= t) code = code + (1 << b);
    end
    exp_final = code;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts a calibration from a negedge and follows it to the done pulse.
  // k counts clock edges after the start-accepting edge.
  task automatic run_cal(input int s, input int hold_code, input int hold_len,
                         input bit do_abort);
    int  k;
    bit  held;
    trials_q.delete();
    lat_g = -1; az_cnt_g = 0; az_first_g = -1; frozen_bad_g = 0;
    held = 0;
    settle_cycles = 8'(s);
    start = 1'b1;
    step();
    start = keep_start;
    manual_en = man_busy;
    k = 0;
    while (k < 3000) begin
      if (done) begin
        lat_g = k;
        break;
      end
      if (az_en) begin
        az_cnt_g++;
        if (az_first_g < 0) az_first_g = k;
      end
      if (busy && !az_en && (trials_q.size() == 0 || trials_q[$] != int'(trim_code)))
        trials_q.push_back(int'(trim_code));
      if (!held && busy && !az_en && int'(trim_code) == hold_code) begin
        held = 1;
        if (do_abort) begin
          abort = 1'b1;
          step();
          abort = 1'b0;
          return;
        end
        ena = 1'b0;
        for (int j = 0; j < hold_len; j++) begin
          step();
          k++;
          if (int'(trim_code) != hold_code || busy !== 1'b1) frozen_bad_g++;
        end
        ena = 1'b1;
      end
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; manual_en = 1'b0;
    manual_code = 6'h15; settle_cycles = 8'd3;
    step(); step();
    vectors++;
    if ({trim_code, az_en, busy, done, trim_valid} !== {6'd32, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_state: got code=%0d az=%b busy=%b done=%b tv=%b, want code=32 and zeros",
               trim_code, az_en, busy, done, trim_valid);
    end
    rst_n = 1'b1;
    step();
    $display("reset: code=%0d", trim_code);
  endtask

  task automatic test_nominal();
    target = 37;
    model_sar(target);
    run_cal(3, -1, 0, 0);
    $display("nominal: lat=%0d code=%0d trials=%p", lat_g, trim_code, trials_q);
    vectors++;
    if (lat_g != 34) begin miscompares++; $display("FAIL nom_latency: got %0d want 34", lat_g); end
    vectors++;
    if (int'(trim_code) != 37) begin miscompares++; $display("FAIL nom_code: got %0d want 37", trim_code); end
    vectors++;
    if (trials_q != exp_q) begin miscompares++; $display("FAIL nom_trials: got %p want %p", trials_q, exp_q); end
    vectors++;
    if (az_first_g != 0 || az_cnt_g != 4) begin
      miscompares++;
      $display("FAIL nom_az_window: got first=%0d count=%0d want first=0 count=4", az_first_g, az_cnt_g);
    end
    step();
    vectors++;
    if (done !== 1'b0 || trim_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL nom_done_pulse: got done=%b tv=%b want done=0 tv=1", done, trim_valid);
    end
  endtask

  task automatic test_rails();
    target = -1;
    run_cal(2, -1, 0, 0);
    $display("rail high comp: lat=%0d code=%0d", lat_g, trim_code);
    vectors++;
    if (lat_g != 27 || int'(trim_code) != 0) begin
      miscompares++;
      $display("FAIL rail_comp1: got lat=%0d code=%0d want lat=27 code=0", lat_g, trim_code);
    end
    target = 63;
    run_cal(2, -1, 0, 0);
    $display("rail low comp: lat=%0d code=%0d", lat_g, trim_code);
    vectors++;
    if (lat_g != 27 || int'(trim_code) != 63) begin
      miscompares++;
      $display("FAIL rail_comp0: got lat=%0d code=%0d want lat=27 code=63", lat_g, trim_code);
    end
  endtask

  task automatic test_abort();
    int seen;
    target = 37;
    run_cal(3, 40, 0, 1);
    $display("abort: code=%0d busy=%b tv=%b az=%b", trim_code, busy, trim_valid, az_en);
    vectors++;
    if ({trim_code, busy, trim_valid, az_en} !== {6'd32, 3'b000}) begin
      miscompares++;
      $display("FAIL abort_state: got code=%0d busy=%b tv=%b az=%b want 32,0,0,0",
               trim_code, busy, trim_valid, az_en);
    end
    seen = 0;
    for (int j = 0; j < 60; j++) begin
      if (done || busy) seen++;
      step();
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen); end
    run_cal(3, -1, 0, 0);
    $display("after abort: lat=%0d code=%0d", lat_g, trim_code);
    vectors++;
    if (lat_g != 34 || int'(trim_code) != 37) begin
      miscompares++;
      $display("FAIL abort_recover: got lat=%0d code=%0d want 34/37", lat_g, trim_code);
    end
  endtask

  task automatic test_manual();
    int bad;
    abort = 1'b1; step(); abort = 1'b0;
    manual_en = 1'b1; manual_code = 6'h15; start = 1'b1;
    bad = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      if (busy !== 1'b0 || trim_code !== 6'h15) bad++;
    end
    start = 1'b0;
    $display("manual idle: code=%0d busy=%b", trim_code, busy);
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL manual_idle: got %0d bad cycles want 0", bad); end
    manual_en = 1'b0;
    target = 37;
    man_busy = 1;
    run_cal(3, -1, 0, 0);
    man_busy = 0;
    $display("manual held during busy: lat=%0d code=%0d", lat_g, trim_code);
    vectors++;
    if (lat_g != 34 || trim_code !== 6'h15) begin
      miscompares++;
      $display("FAIL manual_busy: got lat=%0d code=%0d want lat=34 code=21", lat_g, trim_code);
    end
    manual_en = 1'b0; #1;
    vectors++;
    if (int'(trim_code) != 37) begin miscompares++; $display("FAIL manual_off: got %0d want 37", trim_code); end
    manual_en = 1'b1; #1;
    vectors++;
    if (trim_code !== 6'h15) begin miscompares++; $display("FAIL manual_on: got %0d want 21", trim_code); end
    manual_en = 1'b0;
    step();
  endtask

  task automatic test_ena_freeze();
    target = 37;
    run_cal(3, 40, 10, 0);
    $display("ena freeze: lat=%0d code=%0d frozen_bad=%0d", lat_g, trim_code, frozen_bad_g);
    vectors++;
    if (lat_g != 44 || int'(trim_code) != 37) begin
      miscompares++;
      $display("FAIL ena_latency: got lat=%0d code=%0d want 44/37", lat_g, trim_code);
    end
    vectors++;
    if (frozen_bad_g != 0) begin miscompares++; $display("FAIL ena_frozen: got %0d moving cycles want 0", frozen_bad_g); end
  endtask

  task automatic test_back_to_back();
    int gap;
    bit tv_low;
    target = 19;
    keep_start = 1;
    run_cal(2, -1, 0, 0);
    gap = -1; tv_low = 0;
    for (int j = 1; j < 200; j++) begin
      step();
      if (j == 1) tv_low = (trim_valid === 1'b0 && busy === 1'b1);
      if (done) begin gap = j; break; end
    end
    start = 1'b0;
    keep_start = 0;
    $display("back-to-back: gap=%0d code=%0d", gap, trim_code);
    vectors++;
    if (gap != 28 || !tv_low) begin
      miscompares++;
      $display("FAIL b2b_gap: got gap=%0d tv_low=%0d want 28/1", gap, tv_low);
    end
    vectors++;
    if (int'(trim_code) != 19) begin miscompares++; $display("FAIL b2b_code: got %0d want 19", trim_code); end
    step();
  endtask

  task automatic test_random();
    int s;
    for (int n = 0; n < 10; n++) begin
      target = int'($urandom_range(70, 0)) - 3;
      s = int'($urandom_range(6, 2));
      model_sar(target);
      run_cal(s, -1, 0, 0);
      $display("random: target=%0d S=%0d lat=%0d code=%0d", target, s, lat_g, trim_code);
      vectors++;
      if (lat_g != (s + 1) + 6 * (s + 2) || int'(trim_code) != exp_final || trials_q != exp_q) begin
        miscompares++;
        $display("FAIL rand_cal: got lat=%0d code=%0d trials=%p want lat=%0d code=%0d trials=%p",
                 lat_g, trim_code, trials_q, (s + 1) + 6 * (s + 2), exp_final, exp_q);
      end
    end
  endtask

  task automatic test_reset_mid();
    target = 37;
    abort = 1'b1; step(); abort = 1'b0;
    settle_cycles = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 13; j++) step();
    rst_n = 1'b0;
    #1;
    $display("reset mid-sample: code=%0d az=%b busy=%b done=%b tv=%b", trim_code, az_en, busy, done, trim_valid);
    vectors++;
    if ({trim_code, az_en, busy, done, trim_valid} !== {6'd32, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_mid: got code=%0d az=%b busy=%b done=%b tv=%b want 32 and zeros",
               trim_code, az_en, busy, done, trim_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_cal(0, -1, 0, 0);
    $display("after reset S=0: lat=%0d", lat_g);
    vectors++;
    if (lat_g != 13) begin miscompares++; $display("FAIL reset_s0_latency: got %0d want 13", lat_g); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_rails();
    test_abort();
    test_manual();
    test_ena_freeze();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
